// File: rtl/dout_emitter_pkg.sv
// Purpose : shared constants, FSM state type and header builder for the serial DOUT emitter.
// Latency : n/a (package only).
// Backpressure: n/a; contents: lane/channel geometry, state_e, build_hdr().
package dout_emitter_pkg;

  localparam int NUM_LANES   = 4;
  localparam int NUM_CH      = 8;
  localparam int SAMPLE_BITS = 24;
  localparam int HDR_BITS    = 8;
  localparam int WORD_BITS   = 32;
  localparam int FRAME_BITS  = 2 * WORD_BITS;  // bits carried per lane per frame
  localparam int FCNT_BITS   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Word header: {reserved 0, channel id, frame counter}.
  function automatic logic [HDR_BITS-1:0] build_hdr(input logic [2:0]           ch_id,
                                                    input logic [FCNT_BITS-1:0] fcnt);
    return {1'b0, ch_id, fcnt};
  endfunction

endpackage

// File: rtl/dout_lane_shifter.sv
// Purpose : one serial lane; 64-bit load/shift register, MSB presented on bit_out.
// Latency : loaded MSB visible the cycle after load; each shift advances one bit next cycle.
// Backpressure: none; ports clk, rst_n, load, shift, load_dat[63:0] in, bit_out out.
module dout_lane_shifter
  import dout_emitter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] load_dat,
  output logic                  bit_out
);

  logic [FRAME_BITS-1:0] sreg;

  // Zero fill: after the 64th shift the register is empty, so the lane
  // idles at 0 during GAP/IDLE without any extra gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_dat;
    end else if (shift) begin
      sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Output is a flop bit directly, so the lane has no combinational path.
  assign bit_out = sreg[FRAME_BITS-1];

endmodule

// File: rtl/dout_emitter.sv
// Purpose : emits 8 captured 24-bit channels as headered words on 4 serial lanes with dclk/drdy.
// Latency : first bit at T+1 after an accepted start; done_o at T+1+64*DCLK_DIV; idle again after GAP_CYCLES more.
// Backpressure: none; start_i while busy is dropped and latches sticky overrun_o. Ports: clk_i, reset_ni,
//               start_i, ch1_i..ch8_i in; busy_o, done_o, overrun_o, drdy_o, dclk_o, dout0_o..dout3_o out.
module dout_emitter
  import dout_emitter_pkg::*;
#(
  parameter int DCLK_DIV   = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic [SAMPLE_BITS-1:0] ch1_i,
  input  logic [SAMPLE_BITS-1:0] ch2_i,
  input  logic [SAMPLE_BITS-1:0] ch3_i,
  input  logic [SAMPLE_BITS-1:0] ch4_i,
  input  logic [SAMPLE_BITS-1:0] ch5_i,
  input  logic [SAMPLE_BITS-1:0] ch6_i,
  input  logic [SAMPLE_BITS-1:0] ch7_i,
  input  logic [SAMPLE_BITS-1:0] ch8_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o,
  output logic                   drdy_o,
  output logic                   dclk_o,
  output logic                   dout0_o,
  output logic                   dout1_o,
  output logic                   dout2_o,
  output logic                   dout3_o
);

  localparam int DIV_W = $clog2(DCLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DCLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_M1  = DIV_W'(DCLK_DIV / 2 - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [5:0]       BIT_LAST = 6'(FRAME_BITS - 1);

  state_e                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [5:0]             bit_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [FCNT_BITS-1:0]   frame_cnt;

  logic [SAMPLE_BITS-1:0] ch [NUM_CH];
  logic                   load;
  logic                   shift;
  logic                   div_last;
  logic [NUM_LANES-1:0]   dout;

  assign ch[0] = ch1_i;
  assign ch[1] = ch2_i;
  assign ch[2] = ch3_i;
  assign ch[3] = ch4_i;
  assign ch[4] = ch5_i;
  assign ch[5] = ch6_i;
  assign ch[6] = ch7_i;
  assign ch[7] = ch8_i;

  assign div_last = (div_cnt == DIV_LAST);
  // Loading in the accepting cycle captures the samples and the pre-increment
  // frame counter; later input changes cannot reach the frame in flight.
  assign load     = (state == IDLE) && start_i;
  // Shift on every bit boundary, including the last, which empties the lane.
  assign shift    = (state == SHIFT) && div_last;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [FRAME_BITS-1:0] lane_dat;

    assign lane_dat = {build_hdr(3'(2 * k),     frame_cnt), ch[2 * k],
                       build_hdr(3'(2 * k + 1), frame_cnt), ch[2 * k + 1]};

    dout_lane_shifter u_shifter (
      .clk     (clk_i),
      .rst_n   (reset_ni),
      .load    (load),
      .shift   (shift),
      .load_dat(lane_dat),
      .bit_out (dout[k])
    );
  end

  assign dout0_o = dout[0];
  assign dout1_o = dout[1];
  assign dout2_o = dout[2];
  assign dout3_o = dout[3];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      drdy_o    <= 1'b0;
      dclk_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i && (state != IDLE)) begin
        overrun_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= SHIFT;
            frame_cnt <= frame_cnt + 4'd1;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            busy_o    <= 1'b1;
            drdy_o    <= 1'b1;
            dclk_o    <= 1'b0;
          end
        end

        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            dclk_o  <= 1'b0;
            drdy_o  <= 1'b0;  // drdy covers only the first bit period
            if (bit_cnt == BIT_LAST) begin
              state   <= GAP;
              done_o  <= 1'b1;
              gap_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            // Next phase is in the upper half of the bit period -> dclk high.
            dclk_o  <= (div_cnt >= HALF_M1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dout_emitter.sv
// Purpose : self-checking bench for dout_emitter (DCLK_DIV=4/GAP=8 and DCLK_DIV=2/GAP=1 instances).
// Latency : n/a.
// Backpressure: n/a; stimulus is a linear sequence of directed/randomized frames.
module tb_dout_emitter;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        start_a;
  logic        start_b;
  logic [23:0] ch [8];

  logic busy_a, done_a, ovr_a_o, drdy_a, dclk_a, d0_a, d1_a, d2_a, d3_a;
  logic busy_b, done_b, ovr_b_o, drdy_b, dclk_b, d0_b, d1_b, d2_b, d3_b;

  always #5 clk = ~clk;

  dout_emitter #(.DCLK_DIV(4), .GAP_CYCLES(8)) dut_a (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_a),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .busy_o(busy_a), .done_o(done_a), .overrun_o(ovr_a_o), .drdy_o(drdy_a), .dclk_o(dclk_a),
    .dout0_o(d0_a), .dout1_o(d1_a), .dout2_o(d2_a), .dout3_o(d3_a)
  );

  dout_emitter #(.DCLK_DIV(2), .GAP_CYCLES(1)) dut_b (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_b),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .busy_o(busy_b), .done_o(done_b), .overrun_o(ovr_b_o), .drdy_o(drdy_b), .dclk_o(dclk_b),
    .dout0_o(d0_b), .dout1_o(d1_b), .dout2_o(d2_b), .dout3_o(d3_b)
  );

  int          checks = 0;
  int          errors = 0;
  int          fc_a   = 0;
  int          fc_b   = 0;
  bit          exp_ovr_a = 1'b0;
  bit          exp_ovr_b = 1'b0;
  bit          use_pat   = 1'b0;
  logic [23:0] pat [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Word as seen by the receiver: {0, channel id, frame counter, sample}.
  function automatic logic [31:0] ref_word(input int idx, input int fc, input logic [23:0] s);
    logic [2:0] id;
    logic [3:0] f;
    id = idx[2:0];
    f  = fc[3:0];
    return {1'b0, id, f, s};
  endfunction

  // {busy, done, overrun, drdy, dclk, lanes[3:0]}
  function automatic logic [8:0] outs(input int sel);
    if (sel == 0) return {busy_a, done_a, ovr_a_o, drdy_a, dclk_a, d3_a, d2_a, d1_a, d0_a};
    return {busy_b, done_b, ovr_b_o, drdy_b, dclk_b, d3_b, d2_b, d1_b, d0_b};
  endfunction

  // Starts a frame at the current negedge and follows it cycle by cycle up to
  // the first idle cycle, returning at that negedge (so back-to-back calls run
  // at minimum spacing). abort_off>0 pulses reset at that offset instead.
  task automatic run_frame(input int sel, input bit inject, input int abort_off, input string name);
    int          div, gap, shift_len, last, fc, rises, phase, bitn;
    int          bad_dclk, bad_drdy, bad_dout, bad_busy, bad_done;
    logic [23:0] smp [8];
    logic [63:0] exp_lane [4];
    logic [63:0] got_lane [4];
    logic [8:0]  o;
    logic [3:0]  e_lane;
    logic        e_dclk, e_drdy, prev_dclk;

    div       = (sel == 0) ? 4 : 2;
    gap       = (sel == 0) ? 8 : 1;
    shift_len = 64 * div;
    last      = shift_len + gap;
    fc        = (sel == 0) ? fc_a : fc_b;
    for (int i = 0; i < 8; i++) smp[i] = use_pat ? pat[i] : 24'($urandom);
    for (int k = 0; k < 4; k++) begin
      exp_lane[k] = {ref_word(2 * k, fc, smp[2 * k]), ref_word(2 * k + 1, fc, smp[2 * k + 1])};
      got_lane[k] = '0;
    end
    for (int i = 0; i < 8; i++) ch[i] = smp[i];
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);

    prev_dclk = 1'b0;
    rises = 0; bad_dclk = 0; bad_drdy = 0; bad_dout = 0; bad_busy = 0; bad_done = 0;
    o = '0;
    for (int off = 1; off <= last + 1; off++) begin
      @(negedge clk);
      o = outs(sel);
      if (off <= shift_len) begin
        bitn   = (off - 1) / div;
        phase  = (off - 1) % div;
        e_dclk = (phase >= div / 2);
        e_drdy = (bitn == 0);
        for (int k = 0; k < 4; k++) e_lane[k] = exp_lane[k][63 - bitn];
      end else begin
        e_dclk = 1'b0;
        e_drdy = 1'b0;
        e_lane = 4'b0;
      end
      if (o[4] !== e_dclk) bad_dclk++;
      if (o[5] !== e_drdy) bad_drdy++;
      if (o[3:0] !== e_lane) bad_dout++;
      if (o[8] !== (off <= last)) bad_busy++;
      if (o[7] !== (off == shift_len + 1)) bad_done++;
      // Receiver view: capture lanes on each dclk rising edge.
      if (o[4] === 1'b1 && prev_dclk === 1'b0) begin
        if (rises < 64) for (int k = 0; k < 4; k++) got_lane[k][63 - rises] = o[k];
        rises++;
      end
      prev_dclk = o[4];

      start_a = 1'b0;
      start_b = 1'b0;
      if (inject && sel == 0 && (off == 50 || off == shift_len + 3)) begin
        start_a   = 1'b1;
        exp_ovr_a = 1'b1;
      end
      for (int i = 0; i < 8; i++) ch[i] = 24'($urandom);

      if (off == abort_off) begin
        reset_ni = 1'b0;
        #1;
        chk({name, "_rst_async"}, 64'(outs(sel)), 64'd0);
        fc_a = 0; fc_b = 0; exp_ovr_a = 1'b0; exp_ovr_b = 1'b0;
        @(negedge clk);
        chk({name, "_rst_held"}, 64'(outs(sel)), 64'd0);
        reset_ni = 1'b1;
        return;
      end
    end

    chk({name, "_rises"}, 64'(rises), 64'd64);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_lane%0d", name, k), got_lane[k], exp_lane[k]);
    chk({name, "_dclk"}, 64'(bad_dclk), 64'd0);
    chk({name, "_drdy"}, 64'(bad_drdy), 64'd0);
    chk({name, "_dout"}, 64'(bad_dout), 64'd0);
    chk({name, "_busy"}, 64'(bad_busy), 64'd0);
    chk({name, "_done"}, 64'(bad_done), 64'd0);
    chk({name, "_overrun"}, 64'(o[6]), 64'((sel == 0) ? exp_ovr_a : exp_ovr_b));
    if (sel == 0) fc_a = (fc_a + 1) % 16; else fc_b = (fc_b + 1) % 16;
  endtask

  initial begin
    #500_000;
    $error("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_ni = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ch[i]  = '0;
      pat[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_a", 64'(outs(0)), 64'd0);
    chk("reset_b", 64'(outs(1)), 64'd0);
    reset_ni = 1'b1;

    // Start on the first edge after release; known-value frame.
    use_pat = 1'b1;
    pat[0] = 24'h123456;
    pat[1] = 24'hABCDEF;
    run_frame(0, 1'b0, 0, "known");

    for (int i = 0; i < 8; i++) pat[i] = 24'(i + 1);
    run_frame(0, 1'b0, 0, "ramp");

    for (int i = 0; i < 8; i++) pat[i] = 24'hFFFFFF;
    run_frame(0, 1'b0, 0, "neg1");
    use_pat = 1'b0;

    // Overrun: start mid-SHIFT and inside GAP.
    run_frame(0, 1'b1, 0, "ovr");
    run_frame(0, 1'b0, 0, "ovr_sticky");

    // Reset at the start of bit 20.
    run_frame(0, 1'b0, 1 + 20 * 4, "midrst");

    // 18 frames at minimum spacing; counter runs 0..15,0,1.
    for (int f = 0; f < 18; f++) run_frame(0, 1'b0, 0, $sformatf("b2b%0d", f));

    // Fast instance: dclk period 2, done at T+129, idle at T+130.
    run_frame(1, 1'b0, 0, "fast0");
    run_frame(1, 1'b0, 0, "fast1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
